// File: rtl/disparity_wta_select.sv
// Winner-take-all disparity selection over a per-pixel Hamming-cost beat stream.
// Tracks best/second-best cost, applies a uniqueness ratio and queues results in a 2-entry FWFT FIFO.
module disparity_wta_select #(
    parameter int NUM_DISP = 64,
    parameter int COST_W   = 8,
    parameter int UNIQ_NUM = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COST_W-1:0] sum_i,
    input  logic [15:0]       coords_i,
    input  logic [15:0]       blk_index_i,
    input  logic              sum_valid_i,
    output logic [15:0]       disp_o,
    output logic [COST_W-1:0] cost_o,
    output logic [15:0]       coords_o,
    output logic              uniq_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              seq_err,
    output logic              overflow
);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_ACCUM  = 1'b1;
    localparam logic [15:0] LAST_IDX = 16'(NUM_DISP - 1);
    localparam bit          SINGLE   = (NUM_DISP == 1);

    // min*16 and second*UNIQ_NUM both fit in COST_W+5 bits, so nothing is truncated.
    function automatic logic f_uniq(input logic [COST_W-1:0] mn, input logic [COST_W-1:0] sec);
        logic [COST_W+4:0] l_lhs;
        logic [COST_W+4:0] l_rhs;
        l_lhs = {5'd0, mn} << 4;
        l_rhs = {5'd0, sec} * (COST_W+5)'(UNIQ_NUM);
        return l_lhs < l_rhs;
    endfunction

    logic [0:0]        r_state;
    logic [15:0]       r_count;
    logic              r_fin_vld;
    logic              r_seq_err;
    logic              r_overflow;
    logic [COST_W-1:0] r_min;
    logic [COST_W-1:0] r_second;
    logic [15:0]       r_best;
    logic [15:0]       r_coords;

    logic w_in_seq;
    logic w_load;
    logic w_update;
    logic w_err;
    logic w_fin;

    assign w_in_seq = (r_state == S_ACCUM) && (blk_index_i == r_count) && (coords_i == r_coords);
    assign w_load   = sum_valid_i && (blk_index_i == 16'd0);
    assign w_update = sum_valid_i && w_in_seq;
    assign w_err    = sum_valid_i && !w_in_seq && ((r_state == S_ACCUM) || (blk_index_i != 16'd0));
    assign w_fin    = (w_load && SINGLE) || (w_update && (blk_index_i == LAST_IDX));

    // Accumulation stage: sequencing control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 16'd0;
            r_fin_vld <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_fin_vld <= w_fin;
            r_seq_err <= w_err;
            if (w_fin) begin
                r_state <= S_IDLE;
                r_count <= 16'd0;
            end else if (w_load) begin
                r_state <= S_ACCUM;
                r_count <= 16'd1;
            end else if (w_update) begin
                r_count <= r_count + 16'd1;
            end else if (w_err) begin
                r_state <= S_IDLE;
                r_count <= 16'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_min    <= sum_i;
            r_second <= '1;
            r_best   <= 16'd0;
            r_coords <= coords_i;
        end else if (w_update) begin
            // Strict compares: on a tie the earlier (lower) index stays the winner.
            if (sum_i < r_min) begin
                r_second <= r_min;
                r_min    <= sum_i;
                r_best   <= blk_index_i;
            end else if (sum_i < r_second) begin
                r_second <= sum_i;
            end
        end
    end

    // Final stage: push the finished pixel into the output FIFO
    logic [15:0]       r_mem_disp   [2];
    logic [COST_W-1:0] r_mem_cost   [2];
    logic [15:0]       r_mem_coords [2];
    logic              r_mem_uniq   [2];
    logic [1:0]        r_cnt;
    logic              r_wr_ptr;
    logic              r_rd_ptr;

    logic w_pop;
    logic w_full;
    logic w_wr_en;

    assign w_pop   = out_valid && out_ready;
    assign w_full  = (r_cnt == 2'd2);
    assign w_wr_en = r_fin_vld && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_disp[i]   <= 16'd0;
                r_mem_cost[i]   <= '0;
                r_mem_coords[i] <= 16'd0;
                r_mem_uniq[i]   <= 1'b0;
            end
            r_cnt      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // When full, a simultaneous pop frees the slot the write pointer targets.
            if (w_wr_en) begin
                r_mem_disp[r_wr_ptr]   <= r_best;
                r_mem_cost[r_wr_ptr]   <= r_min;
                r_mem_coords[r_wr_ptr] <= r_coords;
                r_mem_uniq[r_wr_ptr]   <= f_uniq(r_min, r_second);
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_wr_en} - {1'b0, w_pop};
            if (r_fin_vld && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (r_cnt != 2'd0);
    assign disp_o    = r_mem_disp[r_rd_ptr];
    assign cost_o    = r_mem_cost[r_rd_ptr];
    assign coords_o  = r_mem_coords[r_rd_ptr];
    assign uniq_o    = r_mem_uniq[r_rd_ptr];
    assign seq_err   = r_seq_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_disparity_wta_select.sv
// Randomized and directed bench for disparity_wta_select (NUM_DISP=4 and NUM_DISP=1 instances)
// with a per-pixel argmin/second-smallest reference model and an expected-result queue.
module tb_disparity_wta_select;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  sum_i;
    logic [15:0] coords_i;
    logic [15:0] blk_index_i;
    logic        sum_valid_i;
    logic        v1;
    logic        out_ready;

    logic [15:0] disp_o, coords_o;
    logic [7:0]  cost_o;
    logic        uniq_o, out_valid, seq_err, overflow;

    logic [15:0] d1_disp, d1_coords;
    logic [7:0]  d1_cost;
    logic        d1_uniq, d1_valid, d1_seq_err, d1_overflow;

    disparity_wta_select #(.NUM_DISP(4), .COST_W(8), .UNIQ_NUM(14)) dut (
        .clk(clk), .reset(reset), .sum_i(sum_i), .coords_i(coords_i),
        .blk_index_i(blk_index_i), .sum_valid_i(sum_valid_i),
        .disp_o(disp_o), .cost_o(cost_o), .coords_o(coords_o), .uniq_o(uniq_o),
        .out_valid(out_valid), .out_ready(out_ready), .seq_err(seq_err), .overflow(overflow)
    );

    disparity_wta_select #(.NUM_DISP(1), .COST_W(8), .UNIQ_NUM(14)) dut1 (
        .clk(clk), .reset(reset), .sum_i(sum_i), .coords_i(coords_i),
        .blk_index_i(blk_index_i), .sum_valid_i(v1),
        .disp_o(d1_disp), .cost_o(d1_cost), .coords_o(d1_coords), .uniq_o(d1_uniq),
        .out_valid(d1_valid), .out_ready(1'b1), .seq_err(d1_seq_err), .overflow(d1_overflow)
    );

    typedef struct packed {
        logic [15:0] disp;
        logic [7:0]  cost;
        logic [15:0] co;
        logic        uniq;
    } res_t;

    res_t q[$];
    res_t held;
    bit   held_vld;
    bit   rdy_rand;
    bit   rdy_dir;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: winner is the first index holding the minimum; second is the smallest
    // cost among the remaining candidates (all-ones when there are none).
    function automatic res_t ref_wta(input logic [15:0] co, input logic [7:0] c0, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] v[4];
        int b;
        int sec;
        res_t r;
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
        b = 0;
        for (int i = 1; i < 4; i++) if (v[i] < v[b]) b = i;
        sec = 255;
        for (int i = 0; i < 4; i++) if (i != b && int'(v[i]) < sec) sec = int'(v[i]);
        r.disp = 16'(b);
        r.cost = v[b];
        r.co   = co;
        r.uniq = (int'(v[b]) * 16 < sec * 14);
        return r;
    endfunction

    function automatic logic [7:0] rc();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel < 3) return 8'($urandom_range(0, 3));
        if (sel == 3) return 8'hFF;
        return 8'($urandom);
    endfunction

    task automatic monitor();
        res_t cur;
        res_t e;
        cur.disp = disp_o; cur.cost = cost_o; cur.co = coords_o; cur.uniq = uniq_o;
        if (held_vld && out_valid) chk("hold_stable", 64'(cur), 64'(held));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 64'(out_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("disp", disp_o, e.disp);
                chk("cost", cost_o, e.cost);
                chk("coords", coords_o, e.co);
                chk("uniq", uniq_o, e.uniq);
            end
            held_vld = 1'b0;
        end else begin
            held_vld = out_valid;
            held     = cur;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_dir;
        monitor();
    endtask

    task automatic beat(input logic [7:0] c, input logic [15:0] co, input logic [15:0] idx);
        tick();
        sum_valid_i = 1'b1; v1 = 1'b0;
        sum_i = c; coords_i = co; blk_index_i = idx;
    endtask

    task automatic beat1(input logic [7:0] c, input logic [15:0] co, input logic [15:0] idx);
        tick();
        sum_valid_i = 1'b0; v1 = 1'b1;
        sum_i = c; coords_i = co; blk_index_i = idx;
    endtask

    task automatic idle();
        tick();
        sum_valid_i = 1'b0; v1 = 1'b0;
    endtask

    task automatic px(input logic [15:0] co, input logic [7:0] c0, input logic [7:0] c1,
                      input logic [7:0] c2, input logic [7:0] c3, input bit gaps, input bit expect_out);
        logic [7:0] c[4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            if (i == 3 && expect_out) q.push_back(ref_wta(co, c0, c1, c2, c3));
            beat(c[i], co, 16'(i));
        end
    endtask

    initial begin
        int w;
        int k;
        int mode;
        logic [15:0] co;
        logic [7:0]  c;

        n_tests = 0; n_fail = 0;
        reset = 1'b1; sum_valid_i = 1'b0; v1 = 1'b0;
        sum_i = 8'd0; coords_i = 16'd0; blk_index_i = 16'd0;
        rdy_dir = 1'b1; rdy_rand = 1'b0; out_ready = 1'b1; held_vld = 1'b0;

        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_disp", disp_o, 0);
        chk("rst_cost", cost_o, 0);
        chk("rst_coords", coords_o, 0);
        chk("rst_uniq", uniq_o, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_d1_valid", d1_valid, 0);
        reset = 1'b0;
        idle(); idle();

        // Basic pixel and two-cycle latency
        px(16'h0305, 8'd9, 8'd3, 8'd7, 8'd5, 1'b0, 1'b1);
        idle();
        chk("t1_latency_early", out_valid, 0);
        idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_disp", disp_o, 1);
        chk("t1_cost", cost_o, 3);
        chk("t1_coords", coords_o, 16'h0305);
        chk("t1_uniq", uniq_o, 1);
        idle();

        // Ties keep the lowest index; uniqueness fails
        px(16'h0102, 8'd4, 8'd6, 8'd4, 8'd4, 1'b0, 1'b1);
        idle(); idle();
        chk("t2_valid", out_valid, 1);
        chk("t2_disp", disp_o, 0);
        chk("t2_cost", cost_o, 4);
        chk("t2_uniq", uniq_o, 0);
        idle();

        // Skipped index aborts the pixel
        beat(8'd1, 16'h0707, 16'd0);
        beat(8'd2, 16'h0707, 16'd1);
        beat(8'd3, 16'h0707, 16'd3);
        idle();
        chk("t3_seq_err", seq_err, 1);
        idle();
        chk("t3_seq_err_pulse", seq_err, 0);
        chk("t3_no_result", out_valid, 0);
        px(16'h0707, 8'd8, 8'd2, 8'd9, 8'd1, 1'b0, 1'b1);
        repeat (3) idle();
        chk("t3_drained", q.size(), 0);

        // Backpressure: two results held, third dropped
        rdy_dir = 1'b0;
        idle();
        px(16'h1001, 8'd10, 8'd20, 8'd30, 8'd1, 1'b0, 1'b1);
        px(16'h1002, 8'd50, 8'd2, 8'd40, 8'd60, 1'b0, 1'b1);
        px(16'h1003, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 1'b0);
        repeat (3) idle();
        chk("t4_overflow", overflow, 1);
        chk("t4_valid", out_valid, 1);
        chk("t4_head_coords", coords_o, 16'h1001);
        chk("t4_head_disp", disp_o, 3);
        rdy_dir = 1'b1;
        repeat (4) idle();
        chk("t4_two_drained", q.size(), 0);
        chk("t4_empty", out_valid, 0);
        chk("t4_overflow_sticky", overflow, 1);

        // Reset mid-pixel with a queued result
        rdy_dir = 1'b0;
        idle();
        px(16'h2001, 8'd7, 8'd7, 8'd1, 8'd7, 1'b0, 1'b0);
        beat(8'd3, 16'h2002, 16'd0);
        beat(8'd4, 16'h2002, 16'd1);
        beat(8'd5, 16'h2002, 16'd2);
        chk("t5_queued", out_valid, 1);
        tick();
        reset = 1'b1; sum_valid_i = 1'b0;
        tick();
        chk("t5_valid_cleared", out_valid, 0);
        chk("t5_overflow_cleared", overflow, 0);
        chk("t5_disp_cleared", disp_o, 0);
        reset = 1'b0;
        q.delete();
        rdy_dir = 1'b1;
        idle();
        px(16'h2003, 8'd90, 8'd80, 8'd70, 8'd60, 1'b0, 1'b1);
        repeat (4) idle();
        chk("t5_only_own", q.size(), 0);
        chk("t5_empty", out_valid, 0);

        // Randomized stream with random backpressure and sequence faults
        rdy_rand = 1'b1;
        for (int p = 0; p < 150; p++) begin
            w = 0;
            while (q.size() > 1 && w < 200) begin
                idle();
                w++;
            end
            if (w >= 200) chk("drain_timeout", q.size(), 1);
            mode = $urandom_range(0, 9);
            co = 16'($urandom);
            if (mode < 7) begin
                px(co, rc(), rc(), rc(), rc(), 1'b1, 1'b1);
            end else if (mode == 7) begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k; i++) beat(rc(), co, 16'(i));
                beat(rc(), co, 16'(k + 1 + $urandom_range(0, 2)));
                idle();
                chk("rand_bad_index", seq_err, 1);
            end else if (mode == 8) begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k; i++) beat(rc(), co, 16'(i));
                beat(rc(), co ^ 16'h0100, 16'(k));
                idle();
                chk("rand_bad_coords", seq_err, 1);
            end else begin
                beat(rc(), co, 16'($urandom_range(1, 65535)));
                idle();
                chk("rand_idle_bad_index", seq_err, 1);
            end
        end
        rdy_rand = 1'b0;
        rdy_dir  = 1'b1;
        w = 0;
        while (q.size() > 0 && w < 50) begin
            idle();
            w++;
        end
        chk("rand_final_drain", q.size(), 0);
        idle(); idle();
        chk("rand_empty", out_valid, 0);
        chk("rand_no_overflow", overflow, 0);

        // Single-candidate configuration
        for (int i = 0; i < 10; i++) begin
            c = (i == 0) ? 8'd17 : (i == 1) ? 8'd223 : (i == 2) ? 8'd224 : (i == 3) ? 8'hFF : 8'($urandom);
            co = 16'($urandom);
            beat1(c, co, 16'd0);
            idle();
            chk("nd1_latency_early", d1_valid, 0);
            idle();
            chk("nd1_valid", d1_valid, 1);
            chk("nd1_disp", d1_disp, 0);
            chk("nd1_cost", d1_cost, c);
            chk("nd1_coords", d1_coords, co);
            chk("nd1_uniq", d1_uniq, (int'(c) * 16 < 255 * 14));
        end
        beat1(8'd5, 16'h0000, 16'd5);
        idle();
        chk("nd1_seq_err", d1_seq_err, 1);
        idle(); idle();
        chk("nd1_no_result", d1_valid, 0);
        chk("nd1_no_overflow", d1_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disparity_wta_select.md
Name: disparity_wta_select

Overview:
- Consumer of the Hamming-cost stream produced by the block-matching cost stage.
- Per pixel coordinate, accepts one cost beat per candidate disparity (blk_index 0..NUM_DISP-1, in order) and performs winner-take-all selection.
- Tracks best cost, second-best cost and best index; emits one result per pixel with a uniqueness flag through a 2-entry valid/ready output FIFO toward the depth writer.

Parameters:
- NUM_DISP, 64, candidate disparities per pixel (1..65535)
- COST_W, 8, cost width; must match the cost stage sum width
- UNIQ_NUM, 14, uniqueness ratio numerator over 16 (0..16)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sum_i  in  COST_W  Hamming cost of current candidate
- coords_i  in  16  pixel coordinates {y[15:8], x[7:0]}
- blk_index_i  in  16  candidate disparity index of current beat
- sum_valid_i  in  1  beat qualifier; no backpressure on input side
- disp_o  out  16  winning disparity index
- cost_o  out  COST_W  winning (minimum) cost
- coords_o  out  16  coordinates of result
- uniq_o  out  1  1 = best match passes uniqueness test
- out_valid  out  1  result available at FIFO head
- out_ready  in  1  downstream accepts head when out_valid & out_ready
- seq_err  out  1  one-cycle pulse on any sequence violation
- overflow  out  1  sticky; result dropped because FIFO full

Behaviour:
- Reset values: out_valid=0, disp_o=0, cost_o=0, coords_o=0, uniq_o=0, seq_err=0, overflow=0; FIFO empty; FSM in IDLE; count=0.
- Reset mid-pixel discards partial accumulation and all FIFO contents.
- FSM states: IDLE, ACCUM.
- IDLE, valid beat with blk_index_i==0:
  - load min=sum_i, second=all-ones, best=0, coords latched, count=1.
  - Go to ACCUM; if NUM_DISP==1, finish immediately instead.
- IDLE, valid beat with blk_index_i!=0: drop beat, pulse seq_err, stay in IDLE.
- ACCUM, valid beat with blk_index_i==count and coords_i==latched:
  - if sum_i<min: second<=min, min<=sum_i, best<=blk_index_i.
  - else if sum_i<second: second<=sum_i.
  - Strict compare, so ties keep the lower index.
  - count++.
  - If blk_index_i==NUM_DISP-1: finish, return to IDLE, count=0.
- ACCUM, valid beat out of sequence (wrong index or coords mismatch): pulse seq_err, discard partial result. Then:
  - if blk_index_i==0: restart with this beat (as in IDLE).
  - otherwise: drop the beat and go to IDLE.
- Invalid cycles (sum_valid_i=0) hold all state; gaps between beats are allowed.
- Finish: the final beat updates min/second/best at edge E. A FINAL register stage pushes the result into the FIFO at edge E+1.
  - uniq = (min*16 < second*UNIQ_NUM), computed at width COST_W+5, no truncation.
  - With NUM_DISP==1, second=all-ones.
- Output FIFO: 2 entries, first-word fall-through.
  - out_valid is high after E+1 when the FIFO was empty; latency from final beat sample to out_valid is 2 cycles.
  - Head is popped on out_valid & out_ready.
  - Outputs hold stable while out_valid & !out_ready.
  - A push and a pop in the same cycle both take effect, including when the FIFO is full; no overflow in that case.
  - Push when full without a simultaneous pop: result dropped, overflow set and held until reset.
- Back-to-back pixels are supported: index 0 of the next pixel may arrive the cycle after the previous final beat. Throughput is 1 beat/cycle.

Test Plan:
- NUM_DISP=4, coords=0x0305, costs 9,3,7,5 consecutive, out_ready=1 -> out_valid 2 cycles after last beat; disp_o=1, cost_o=3, coords_o=0x0305. Second=5, 3*16=48 < 5*14=70, so uniq_o=1.
- NUM_DISP=4, costs 4,6,4,4 -> disp_o=0 (tie keeps lowest); second=4, 64<56 false, so uniq_o=0.
- NUM_DISP=4, beats idx 0,1,3 -> seq_err pulse on idx 3, no result, FSM in IDLE. Next full 0..3 sequence produces a normal result.
- NUM_DISP=4, out_ready=0, three back-to-back pixels -> first two results held in order. Third dropped with overflow=1 and held; after out_ready=1 exactly two results drain.
- Reset asserted after idx 2 of a pixel with one result already queued -> out_valid=0 next cycle, FIFO empty. A subsequent idx 0..3 pixel produces only its own result.
- NUM_DISP=1, cost 17 -> disp_o=0, cost_o=17, uniq_o=1 (272 < 255*14).
